// File: rtl/load_unit_pkg.sv
// Shared definitions for the RV32 data-memory load path: funct3 codes,
// FSM states and the word-boundary crossing rule.
package load_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_W0,
        ST_RD1,
        ST_W1,
        ST_RESP
    } state_e;

    function automatic logic f3_legal(input logic [F3_W-1:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // True when the access spills into the next word.
    function automatic logic load_crosses(input logic [F3_W-1:0] f3, input logic [1:0] off);
        logic c;
        c = 1'b0;
        if (f3 == F3_LW) begin
            c = (off != 2'b00);
        end else if ((f3 == F3_LH) || (f3 == F3_LHU)) begin
            c = (off == 2'b11);
        end
        return c;
    endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Combinational align-and-extend: picks the addressed byte/halfword/word out
// of a little-endian word pair and sign- or zero-extends it.
module load_extract
    import load_unit_pkg::*;
(
    input  logic [XLEN-1:0] word0,
    input  logic [XLEN-1:0] word1,
    input  logic [1:0]      offset,
    input  logic [F3_W-1:0] funct3,
    output logic [XLEN-1:0] data
);

    logic [2*XLEN-1:0] pair;
    logic [2*XLEN-1:0] shifted;

    always_comb begin
        pair    = {word1, word0};
        shifted = pair >> {offset, 3'b000};
        data    = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LW:   data = shifted[XLEN-1:0];
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, issues one or two word reads to a
// 1-cycle synchronous memory and returns the extended result with its tag.
module load_unit
    import load_unit_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [F3_W-1:0] req_funct3,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [RD_W-1:0] resp_rd,
    output logic            resp_err
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [F3_W-1:0] f3_q, f3_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            cross_q, cross_d;
    logic [XLEN-1:0] word0_q, word0_d;

    logic            req_ready_d;
    logic            mem_rd_en_d;
    logic [XLEN-1:0] mem_addr_d;
    logic            resp_valid_d;
    logic [XLEN-1:0] resp_data_d;
    logic [RD_W-1:0] resp_rd_d;
    logic            resp_err_d;

    logic            acc_cross;
    logic [XLEN-1:0] word_base;
    logic [XLEN-1:0] ext_word0;
    logic [XLEN-1:0] ext_word1;
    logic [XLEN-1:0] ext_data;

    // In W0 the live read is the low word; in W1 it is the high word.
    always_comb begin
        ext_word0 = mem_rdata;
        ext_word1 = '0;
        if (state_q == ST_W1) begin
            ext_word0 = word0_q;
            ext_word1 = mem_rdata;
        end
    end

    load_extract u_extract (
        .word0  (ext_word0),
        .word1  (ext_word1),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        rd_d         = rd_q;
        cross_d      = cross_q;
        word0_d      = word0_q;
        resp_data_d  = resp_data;
        resp_rd_d    = resp_rd;
        resp_err_d   = resp_err;
        acc_cross    = load_crosses(req_funct3, req_addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    rd_d    = req_rd;
                    cross_d = acc_cross;
                    if (!f3_legal(req_funct3) || (acc_cross && !SPLIT_EN)) begin
                        state_d     = ST_RESP;
                        resp_data_d = '0;
                        resp_rd_d   = req_rd;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d = ST_RD0;
                    end
                end
            end
            ST_RD0: state_d = ST_W0;
            ST_W0: begin
                word0_d = mem_rdata;
                if (cross_q) begin
                    state_d = ST_RD1;
                end else begin
                    state_d     = ST_RESP;
                    resp_data_d = ext_data;
                    resp_rd_d   = rd_q;
                    resp_err_d  = 1'b0;
                end
            end
            ST_RD1: state_d = ST_W1;
            ST_W1: begin
                state_d     = ST_RESP;
                resp_data_d = ext_data;
                resp_rd_d   = rd_q;
                resp_err_d  = 1'b0;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        word_base    = {addr_d[XLEN-1:2], 2'b00};
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        mem_rd_en_d  = (state_d == ST_RD0) || (state_d == ST_RD1);
        mem_addr_d   = mem_addr;
        if (state_d == ST_RD0) begin
            mem_addr_d = word_base;
        end else if (state_d == ST_RD1) begin
            mem_addr_d = word_base + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            cross_q    <= 1'b0;
            word0_q    <= '0;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            cross_q    <= cross_d;
            word0_q    <= word0_d;
            req_ready  <= req_ready_d;
            mem_rd_en  <= mem_rd_en_d;
            mem_addr   <= mem_addr_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_rd    <= resp_rd_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule
